arbiter_rr2: RTL and testbench
==============================

# arbiter_rr2

Two-requester round-robin arbiter with grant hold and bounded-tenure preemption. It is the design under test for the arbitration checker: it drives `gnt_0`/`gnt_1` from `req_0`/`req_1` on a shared resource. Grants are registered and mutually exclusive, and a grant is never issued to an idle requester. A long-holding requester is pre-empted after `MAX_HOLD` cycles when the other side is waiting.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester waits. 0 disables preemption. Legal range 0..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_0` in 1: request from port 0, level; held until done.
- `req_1` in 1: request from port 1, level; held until done.
- `gnt_0` out 1: grant to port 0, registered.
- `gnt_1` out 1: grant to port 1, registered.
- `preempt` out 1: one-cycle pulse on the first grant cycle after a forced handover.

## Operation
- States:
  - IDLE: no grant.
  - GNT0: `gnt_0`=1.
  - GNT1: `gnt_1`=1.
  - `gnt_0`/`gnt_1` are a direct decode of a registered state, so they are never both 1.
- `last` register (1 bit): port that most recently held a grant. Reset value 1, so port 0 wins the first contention.
- `hold_cnt` register, width $clog2(MAX_HOLD+2):
  - Set to 1 on entering GNT0/GNT1.
  - Increments each cycle in the same grant state.
  - Saturates at MAX_HOLD+1.
  - Value 0 in IDLE.
- IDLE transitions:
  - Only `req_0` → GNT0.
  - Only `req_1` → GNT1.
  - Both → port != `last`.
  - Neither → stay.
- GNT0 transitions (GNT1 symmetric):
  - `req_0`=0 and `req_1`=1 → GNT1, with no idle bubble.
  - `req_0`=0 and `req_1`=0 → IDLE.
  - `req_0`=1, `req_1`=1, MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD → GNT1, and `preempt`=1 next cycle.
  - Otherwise stay.
- `last` updates to the new owner on every entry into GNT0/GNT1.
- A pre-empted requester that keeps `req` high is re-granted through the normal handover once the other side releases, or after its own MAX_HOLD.
- No request queueing. A request dropped before being granted is forgotten.

## Timing
- Reset (`reset`=0 at a rising edge) → next cycle:
  - state IDLE
  - `gnt_0`=0, `gnt_1`=0, `preempt`=0
  - `hold_cnt`=0
  - `last`=1
- Reset overrides everything. A grant active at reset drops on the following cycle regardless of `req`.
- Grant latency: `req` sampled high at edge N → `gnt` high from cycle N+1. Minimum latency is 1 cycle.
- Release latency: `req` sampled low at edge N → `gnt` low from cycle N+1. `gnt` may therefore be high for exactly one cycle after `req` falls; checkers apply gnt→req with a one-cycle lag.
- Handover: `gnt_0` falls and `gnt_1` rises in the same cycle.
- Preemption: with continuous contention, each grant lasts exactly MAX_HOLD cycles.
- Without contention, a grant lasts as long as `req` is held. `hold_cnt` saturates and no preemption occurs.
- `preempt` is high for exactly one cycle and only together with a newly risen grant. It is never asserted on voluntary handover or from IDLE.
- MAX_HOLD=1 with both requests held → grants alternate every cycle, `preempt`=1 each cycle.

## Test plan
- Reset with `req_0`=`req_1`=1, release reset at cycle 0 → `gnt_0`=1 from cycle 1, `gnt_1`=0.
- MAX_HOLD=4, `req_0`=`req_1`=1 held for 20 cycles → grants alternate in blocks of 4 cycles (0,1,0,1,0). `preempt` pulses at cycles 5, 9, 13, 17. Never both grants high.
- `req_0` alone for 10 cycles → `gnt_0` high cycles 1–10, then low. No `preempt`, `gnt_1`=0 throughout.
- `gnt_0` active, `req_0` drops at cycle N with `req_1`=1 → `gnt_0`=0 and `gnt_1`=1 at N+1. `preempt`=0.
- `gnt_1` active from cycle 3, `reset` asserted at cycle 6 → both grants 0 at cycle 7. After release with both requests high, `gnt_0` wins.
- MAX_HOLD=0, both requests held for 50 cycles → `gnt_0` held all 50 cycles, `preempt` never asserted.

Source files
------------

// File: rtl/arbiter_rr2.sv
// -----------------------------------------------------------------------------
// arbiter_rr2
// Two-requester round-robin arbiter with grant hold and bounded-tenure
// preemption. A requester keeps its grant for as long as it holds its request,
// unless the other side is also requesting and the owner has already held the
// grant for MAX_HOLD consecutive cycles. In that case ownership is forced over
// and 'preempt' pulses on the first cycle of the new grant.
//
// Parameters:
//   MAX_HOLD  : consecutive grant cycles allowed under contention (0..255).
//               0 disables preemption.
// Ports:
//   clk       in  : single clock, rising edge
//   reset     in  : synchronous, active-low reset
//   req_0     in  : level request from port 0
//   req_1     in  : level request from port 1
//   gnt_0     out : registered grant to port 0
//   gnt_1     out : registered grant to port 1
//   preempt   out : registered one-cycle pulse on the first cycle of a
//                   forced handover
// -----------------------------------------------------------------------------
module arbiter_rr2 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1,
    output logic preempt
);

    // Counter must be able to hold MAX_HOLD+1 (its saturation value).
    localparam int unsigned CW = $clog2(MAX_HOLD + 2);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_SAT   = CW'(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_ONE   = CW'(1);
    localparam logic [CW-1:0] HOLD_ZERO  = CW'(0);
    localparam logic          PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic            last_q,     last_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            preempt_q,  preempt_d;
    logic            gnt_0_q,    gnt_0_d;
    logic            gnt_1_q,    gnt_1_d;

    // Next-state decode: arbitration from IDLE and handover/preemption rules.
    always_comb begin
        state_d   = state_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    // Contention: the port that did not hold the grant last wins.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!req_0) begin
                    // Voluntary release; hand straight over if the other side waits.
                    state_d = req_1 ? GNT1 : IDLE;
                end else if (req_1 && PREEMPT_EN && (hold_cnt_q == HOLD_LIMIT)) begin
                    state_d   = GNT1;
                    preempt_d = 1'b1;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (!req_1) begin
                    state_d = req_0 ? GNT0 : IDLE;
                end else if (req_0 && PREEMPT_EN && (hold_cnt_q == HOLD_LIMIT)) begin
                    state_d   = GNT0;
                    preempt_d = 1'b1;
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tenure counter, last-owner tracking and registered grant decode.
    always_comb begin
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gnt_0_d    = (state_d == GNT0);
        gnt_1_d    = (state_d == GNT1);
        if (state_d == IDLE) begin
            hold_cnt_d = HOLD_ZERO;
        end else if (state_d != state_q) begin
            // New tenure starts: count restarts and the new owner is remembered.
            hold_cnt_d = HOLD_ONE;
            last_d     = (state_d == GNT1);
        end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= HOLD_ZERO;
            preempt_q  <= 1'b0;
            gnt_0_q    <= 1'b0;
            gnt_1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
            gnt_0_q    <= gnt_0_d;
            gnt_1_q    <= gnt_1_d;
        end
    end

    assign gnt_0   = gnt_0_q;
    assign gnt_1   = gnt_1_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_arbiter_rr2.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr2
// Directed bench for arbiter_rr2. Three instances share clock, reset and
// requests: MAX_HOLD=4 (u_dut4), MAX_HOLD=1 (u_dut1), MAX_HOLD=0 (u_dut0).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so "cycle k" is the period following rising edge k counted
// from the reset-release edge.
// -----------------------------------------------------------------------------
module tb_arbiter_rr2;

    logic clk;
    logic reset;
    logic req_0;
    logic req_1;
    logic g0_4, g1_4, p_4;
    logic g0_1, g1_1, p_1;
    logic g0_0, g1_0, p_0;

    int n_tests = 0;
    int n_fail  = 0;

    arbiter_rr2 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
        .gnt_0(g0_4), .gnt_1(g1_4), .preempt(p_4)
    );
    arbiter_rr2 #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
        .gnt_0(g0_1), .gnt_1(g1_1), .preempt(p_1)
    );
    arbiter_rr2 #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
        .gnt_0(g0_0), .gnt_1(g1_0), .preempt(p_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag,
                          input logic g0, input logic g1, input logic p,
                          input logic e0, input logic e1, input logic ep);
        check({tag, ".gnt_0"},   g0, e0);
        check({tag, ".gnt_1"},   g1, e1);
        check({tag, ".preempt"}, p,  ep);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with given request levels; returns 1 unit after the release edge
    // has been scheduled (reset high is sampled at the next edge = cycle 1).
    task automatic do_reset(input logic r0, input logic r1);
        reset = 1'b0;
        req_0 = r0;
        req_1 = r1;
        step();
        step();
        check3("rst.d4", g0_4, g1_4, p_4, 1'b0, 1'b0, 1'b0);
        check3("rst.d1", g0_1, g1_1, p_1, 1'b0, 1'b0, 1'b0);
        check3("rst.d0", g0_0, g1_0, p_0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;

        // 1) Continuous contention from reset: first grant to port 0, then
        //    blocks of MAX_HOLD; MAX_HOLD=1 alternates; MAX_HOLD=0 never moves.
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            logic e0, ep;
            step();
            e0 = (((k - 1) / 4) % 2) == 0;
            ep = (k > 1) && (((k - 1) % 4) == 0);
            check3($sformatf("cont.d4.c%0d", k), g0_4, g1_4, p_4, e0, !e0, ep);
            check3($sformatf("cont.d1.c%0d", k), g0_1, g1_1, p_1,
                   (k % 2) == 1, (k % 2) == 0, k > 1);
            check3($sformatf("cont.d0.c%0d", k), g0_0, g1_0, p_0, 1'b1, 1'b0, 1'b0);
        end

        // 2) Port 0 alone for 10 cycles: grant tracks request, no preemption.
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            step();
            check3($sformatf("solo.d4.c%0d", k), g0_4, g1_4, p_4, k <= 10, 1'b0, 1'b0);
            check3($sformatf("solo.d1.c%0d", k), g0_1, g1_1, p_1, k <= 10, 1'b0, 1'b0);
            if (k == 10) req_0 = 1'b0;
        end

        // 3) Voluntary handover: port 0 granted, port 1 joins, port 0 drops.
        do_reset(1'b1, 1'b0);
        step();                                   // cycle 1
        check3("vol.d4.c1", g0_4, g1_4, p_4, 1'b1, 1'b0, 1'b0);
        req_1 = 1'b1;
        step();                                   // cycle 2
        check3("vol.d4.c2", g0_4, g1_4, p_4, 1'b1, 1'b0, 1'b0);
        check3("vol.d1.c2", g0_1, g1_1, p_1, 1'b0, 1'b1, 1'b1);
        req_0 = 1'b0;
        step();                                   // cycle 3
        check3("vol.d4.c3", g0_4, g1_4, p_4, 1'b0, 1'b1, 1'b0);
        check3("vol.d0.c3", g0_0, g1_0, p_0, 1'b0, 1'b1, 1'b0);
        check3("vol.d1.c3", g0_1, g1_1, p_1, 1'b0, 1'b1, 1'b0);
        step();                                   // cycle 4
        check3("vol.d4.c4", g0_4, g1_4, p_4, 1'b0, 1'b1, 1'b0);

        // 4) Reset during a port-1 grant drops it; port 0 wins afterwards.
        do_reset(1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check3($sformatf("mid.d4.c%0d", k), g0_4, g1_4, p_4, 1'b0, 1'b1, 1'b0);
        end
        reset = 1'b0;
        req_0 = 1'b1;
        step();                                   // cycle 4: reset sampled
        check3("mid.d4.c4", g0_4, g1_4, p_4, 1'b0, 1'b0, 1'b0);
        check3("mid.d0.c4", g0_0, g1_0, p_0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();                                   // cycle 5
        check3("mid.d4.c5", g0_4, g1_4, p_4, 1'b1, 1'b0, 1'b0);
        check3("mid.d0.c5", g0_0, g1_0, p_0, 1'b1, 1'b0, 1'b0);

        // 5) Reset while port 0 owns (last owner 0): last must return to 1,
        //    so port 0 wins the next contention again.
        reset = 1'b0;
        step();
        check3("last.d0.rst", g0_0, g1_0, p_0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check3("last.d0.c1", g0_0, g1_0, p_0, 1'b1, 1'b0, 1'b0);
        check3("last.d4.c1", g0_4, g1_4, p_4, 1'b1, 1'b0, 1'b0);

        // 6) Request dropped before grant is forgotten; both idle return to IDLE.
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
        step();
        check3("idle.d4", g0_4, g1_4, p_4, 1'b0, 1'b0, 1'b0);
        check3("idle.d1", g0_1, g1_1, p_1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
